ahb_lite_regfile: RTL and testbench

AHB_LITE_REGFILE -- requirements
Module: ahb_lite_regfile

---
 rtl/ahb_lite_regfile.sv | 110 +++++++++++
 tb/tb_ahb_lite_regfile.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ahb_lite_regfile.sv
// AHB-Lite slave register file: DEPTH x DATA_WIDTH registers, optional
// wait states on OKAY transfers, two-cycle ERROR response for addresses
// outside the register range.
module ahb_lite_regfile #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write,
  input  logic                  trans,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  readyout,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  resp
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // counter holds WAIT_STATES-1 down to 0
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t                             state_q, state_d;
  logic                               write_q, write_d;
  logic                               range_q, range_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   regs_q, regs_d;
  logic                               in_range;
  logic                               accept;

  // Full-width compare: any bit above the index range makes it out of range
  assign in_range = ({1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH));

  // Next-state, register update and bus outputs
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    range_d  = range_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    regs_d   = regs_q;
    readyout = 1'b1;
    resp     = 1'b0;
    rdata    = '0;
    accept   = 1'b0;

    case (state_q)
      IDLE: ;
      WAIT: begin
        readyout = 1'b0;
        if (cnt_q == '0) state_d = DATA;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DATA: begin
        // write data is sampled on the edge that ends the data phase
        if (write_q && range_q) regs_d[idx_q] = wdata;
      end
      ERR1: begin
        readyout = 1'b0;
        resp     = 1'b1;
        state_d  = ERR2;
      end
      ERR2: resp = 1'b1;
      default: state_d = IDLE;
    endcase

    // Any state that ends with readyout=1 may accept the next address phase
    if (state_q == IDLE || state_q == DATA || state_q == ERR2) begin
      accept = trans & readyout;
      if (accept) begin
        write_d = write;
        range_d = in_range;
        idx_d   = addr[IW-1:0];
        cnt_d   = CNT_LOAD;
        if (!in_range)            state_d = ERR1;
        else if (WAIT_STATES > 0) state_d = WAIT;
        else                      state_d = DATA;
      end else begin
        state_d = IDLE;
      end
    end

    if ((state_q == WAIT || state_q == DATA) && !write_q && range_q)
      rdata = regs_q[idx_q];
  end

  // State and register file flops; reset aborts any transfer in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      range_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      range_q <= range_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_ahb_lite_regfile.sv
// Directed bench: one zero-wait instance and one two-wait-state instance
// sharing clock and reset.
module tb_ahb_lite_regfile;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic       write0, trans0, ready0, resp0;
  logic [7:0] addr0, wdata0, rdata0;
  logic       write2, trans2, ready2, resp2;
  logic [7:0] addr2, wdata2, rdata2;

  ahb_lite_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .write(write0), .trans(trans0), .addr(addr0),
    .wdata(wdata0), .readyout(ready0), .rdata(rdata0), .resp(resp0));

  ahb_lite_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .write(write2), .trans(trans2), .addr(addr2),
    .wdata(wdata2), .readyout(ready2), .rdata(rdata2), .resp(resp2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Two-wait-state write; wdata held through the whole data phase
  task automatic wr_ws2(input logic [7:0] a, input logic [7:0] d, input string tag);
    trans2 = 1'b1; write2 = 1'b1; addr2 = a;
    step;
    trans2 = 1'b0; write2 = 1'b0; wdata2 = d;
    for (int n = 0; n < 2; n++) begin
      chk({tag, "_wait_rdy"}, 32'(ready2), 0);
      step;
    end
    chk({tag, "_done_rdy"}, 32'(ready2), 1);
    chk({tag, "_done_resp"}, 32'(resp2), 0);
    step;
  endtask

  // Two-wait-state read; a write to addr 9 is requested while readyout=0
  // and must be ignored
  task automatic rd_ws2(input logic [7:0] a, input logic [7:0] exp, input string tag);
    trans2 = 1'b1; write2 = 1'b0; addr2 = a;
    step;
    trans2 = 1'b1; write2 = 1'b1; addr2 = 8'd9; wdata2 = 8'h77;
    for (int n = 0; n < 2; n++) begin
      chk({tag, "_wait_rdy"}, 32'(ready2), 0);
      chk({tag, "_wait_resp"}, 32'(resp2), 0);
      chk({tag, "_wait_rd"}, 32'(rdata2), 32'(exp));
      step;
    end
    trans2 = 1'b0; write2 = 1'b0;
    chk({tag, "_done_rdy"}, 32'(ready2), 1);
    chk({tag, "_done_resp"}, 32'(resp2), 0);
    chk({tag, "_done_rd"}, 32'(rdata2), 32'(exp));
    step;
  endtask

  initial begin
    reset_n = 1'b0;
    {write0, trans0, addr0, wdata0} = '0;
    {write2, trans2, addr2, wdata2} = '0;
    #2;
    chk("rst_rdy0", 32'(ready0), 1);
    chk("rst_resp0", 32'(resp0), 0);
    chk("rst_rd0", 32'(rdata0), 0);
    chk("rst_rdy2", 32'(ready2), 1);
    @(negedge clock);
    reset_n = 1'b1;

    // write 0x5A to addr 3, then read it back-to-back
    trans0 = 1'b1; write0 = 1'b1; addr0 = 8'd3;
    step;
    chk("b2b_wr_rdy", 32'(ready0), 1);
    chk("b2b_wr_resp", 32'(resp0), 0);
    write0 = 1'b0; wdata0 = 8'h5A;
    step;
    chk("b2b_rd_data", 32'(rdata0), 32'h5A);
    chk("b2b_rd_rdy", 32'(ready0), 1);
    chk("b2b_rd_resp", 32'(resp0), 0);
    trans0 = 1'b0;
    step;
    chk("idle_rd", 32'(rdata0), 0);
    chk("idle_rdy", 32'(ready0), 1);

    // out-of-range write (addr 20 aliases 4 in the low bits), then read addr 4
    trans0 = 1'b1; write0 = 1'b1; addr0 = 8'd20;
    step;
    chk("err1_rdy", 32'(ready0), 0);
    chk("err1_resp", 32'(resp0), 1);
    wdata0 = 8'hFF; write0 = 1'b0; addr0 = 8'd4;
    step;
    chk("err2_rdy", 32'(ready0), 1);
    chk("err2_resp", 32'(resp0), 1);
    step;
    chk("after_err_rd", 32'(rdata0), 0);
    chk("after_err_resp", 32'(resp0), 0);
    chk("after_err_rdy", 32'(ready0), 1);
    trans0 = 1'b0;
    step;

    // pipelined write sweep 0x01..0x10 to addrs 0..15, then read sweep
    for (int k = 0; k < 32; k++) begin
      trans0 = 1'b1;
      write0 = (k < 16);
      addr0  = 8'(k % 16);
      wdata0 = 8'(k);
      if (k >= 1 && k <= 16) chk("sweep_wr_rdy", 32'(ready0), 1);
      if (k >= 17) chk("sweep_rd", 32'(rdata0), 32'(k - 16));
      step;
    end
    trans0 = 1'b0;
    chk("sweep_rd_last", 32'(rdata0), 32'h10);
    step;

    // two wait states: read after reset, write/read, ignored request
    rd_ws2(8'd0, 8'h00, "ws_rd0");
    wr_ws2(8'd2, 8'hA5, "ws_wr2");
    rd_ws2(8'd2, 8'hA5, "ws_rd2");
    rd_ws2(8'd9, 8'h00, "ws_rd9");

    // reset in the middle of a write wait
    trans2 = 1'b1; write2 = 1'b1; addr2 = 8'd7;
    step;
    trans2 = 1'b0; write2 = 1'b0; wdata2 = 8'h33;
    chk("midrst_wait_rdy", 32'(ready2), 0);
    #3;
    reset_n = 1'b0;
    #2;
    chk("midrst_rdy", 32'(ready2), 1);
    chk("midrst_resp", 32'(resp2), 0);
    chk("midrst_rd", 32'(rdata2), 0);
    @(negedge clock);
    reset_n = 1'b1;
    rd_ws2(8'd7, 8'h00, "post_rst_rd7");
    rd_ws2(8'd2, 8'h00, "post_rst_rd2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
